// File: rtl/riscv_mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of the unified memory arbiter.
// slave = arbiter view, master = core/memory environment view.
interface riscv_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_type;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_type, mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_type, mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares one word-wide memory between RV32I fetch and load/store ports: round-robin
// grant in IDLE, byte-lane steering, load extension, alignment checks, request timeout.
module riscv_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    riscv_mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  r_state;
    logic        r_last_d;
    logic [31:0] r_cnt;
    logic        r_resp_d;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [2:0]  r_type;
    logic [1:0]  r_off;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;

    logic        w_idle, w_resp, w_gnt_i, w_gnt_d, w_bad_i, w_bad_d, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_lane, w_load;

    // On conflict the requester that did not win last time gets the grant.
    assign w_idle  = (r_state == S_IDLE);
    assign w_resp  = (r_state == S_RESP);
    assign w_gnt_i = w_idle && bus.if_req && (!bus.d_req || r_last_d);
    assign w_gnt_d = w_idle && bus.d_req && (!bus.if_req || !r_last_d);
    assign w_bad_i = (bus.if_addr[1:0] != 2'b00);

    always_comb begin
        w_bad_d = 1'b0;
        w_be    = 4'b1111;
        w_wdata = bus.d_wdata;
        case (bus.d_type)
            3'd0, 3'd3: begin
                w_be    = 4'b0001 << bus.d_addr[1:0];
                w_wdata = {4{bus.d_wdata[7:0]}};
            end
            3'd1, 3'd4: begin
                w_bad_d = bus.d_addr[0];
                w_be    = 4'b0011 << bus.d_addr[1:0];
                w_wdata = {2{bus.d_wdata[15:0]}};
            end
            3'd2:    w_bad_d = (bus.d_addr[1:0] != 2'b00);
            default: w_bad_d = 1'b1;
        endcase
    end

    assign w_lane = bus.mem_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_type)
            3'd0:    w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'd1:    w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'd3:    w_load = {24'd0, w_lane[7:0]};
            3'd4:    w_load = {16'd0, w_lane[15:0]};
            default: w_load = w_lane;
        endcase
    end

    // Abort on the wait cycle that brings the counter up to the limit.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && ((r_cnt + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_d    <= 1'b0;
            r_cnt       <= '0;
            r_resp_d    <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_type      <= '0;
            r_off       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_gnt_i) begin
                        r_last_d <= 1'b0;
                        r_resp_d <= 1'b0;
                        r_type   <= 3'd2;
                        r_off    <= 2'b00;
                        if (w_bad_i) begin
                            r_state <= S_RESP;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state     <= S_BUSY_I;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= {bus.if_addr[31:2], 2'b00};
                            r_mem_be    <= 4'b1111;
                            r_mem_wdata <= '0;
                        end
                    end else if (w_gnt_d) begin
                        r_last_d <= 1'b1;
                        r_resp_d <= 1'b1;
                        r_type   <= bus.d_type;
                        r_off    <= bus.d_addr[1:0];
                        if (w_bad_d) begin
                            r_state <= S_RESP;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state     <= S_BUSY_D;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.d_we;
                            r_mem_addr  <= {bus.d_addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (bus.mem_ack) begin
                        r_state   <= S_RESP;
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b0;
                        if (r_state == S_BUSY_I) r_rdata <= bus.mem_rdata;
                        else                     r_rdata <= r_mem_we ? 32'd0 : w_load;
                    end else if (w_timeout) begin
                        r_state   <= S_RESP;
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_rdata   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = w_gnt_i;
    assign bus.d_gnt     = w_gnt_d;
    assign bus.if_rvalid = w_resp && !r_resp_d;
    assign bus.d_rvalid  = w_resp && r_resp_d;
    assign bus.if_rdata  = bus.if_rvalid ? r_rdata : 32'd0;
    assign bus.d_rdata   = bus.d_rvalid ? r_rdata : 32'd0;
    assign bus.if_err    = bus.if_rvalid && r_err;
    assign bus.d_err     = bus.d_rvalid && r_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboarded bench for riscv_mem_arbiter: directed accesses push expected grants,
// memory transactions and responses; negedge monitors pop and compare.
module tb_riscv_mem_arbiter;
    logic clk;
    logic rst_n;
    riscv_mem_arbiter_if bus();

    riscv_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
    } memx_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memdata;
        int          waits;
        bit          noack;
        bit          has_mem;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        int          len;
    } vec_t;

    resp_t resp_q[$];
    memx_t mem_q[$];
    bit    gnt_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int gnt_cyc  = 0;

    logic [31:0] mem_data  = 32'h0;
    int          mem_waits = 0;
    bit          mem_noack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Memory model: acks after mem_waits cycles of a held request unless mem_noack.
    int mem_cnt = 0;
    always @(negedge clk) begin
        bus.mem_rdata = mem_data;
        if (bus.mem_req === 1'b1) begin
            bus.mem_ack = (mem_cnt == mem_waits) && !mem_noack;
            mem_cnt++;
        end else begin
            bus.mem_ack = 1'b0;
            mem_cnt = 0;
        end
    end

    // Grant monitor
    always @(negedge clk) begin
        if (bus.if_gnt === 1'b1 || bus.d_gnt === 1'b1) begin
            gnt_cyc = cyc;
            if (gnt_q.size() == 0) begin
                chk("unexpected_gnt", 32'(bus.d_gnt), 32'hFFFF_FFFF);
            end else begin
                bit exp_d;
                exp_d = gnt_q.pop_front();
                chk("gnt_is_d", 32'(bus.d_gnt), 32'(exp_d));
                chk("gnt_is_i", 32'(bus.if_gnt), 32'(!exp_d));
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (bus.if_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_rvalid", 32'(bus.d_rvalid), 32'hFFFF_FFFF);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("rsp_is_d", 32'(bus.d_rvalid), 32'(e.is_d));
                chk("rsp_rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
                chk("rsp_err", 32'(e.is_d ? bus.d_err : bus.if_err), 32'(e.err));
                chk("rsp_latency", 32'(cyc - gnt_cyc), 32'(e.lat));
            end
        end
    end

    // Memory-side monitor: checks the transaction on its first cycle, stability and length after.
    bit          in_run = 1'b0;
    int          run_len = 0;
    memx_t       cur;
    logic [35:0] first_sig;
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) begin
            if (!in_run) begin
                in_run  = 1'b1;
                run_len = 0;
                first_sig = {bus.mem_be, bus.mem_addr};
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'(bus.mem_req), 32'h0);
                    cur = '{we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0, len: 0};
                end else begin
                    cur = mem_q.pop_front();
                    chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
                    chk("mem_addr", bus.mem_addr, cur.addr);
                    chk("mem_be", 32'(bus.mem_be), 32'(cur.be));
                    if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
                end
            end else begin
                chk("mem_stable", bus.mem_addr ^ first_sig[31:0], 32'h0);
            end
            run_len++;
        end else if (in_run) begin
            in_run = 1'b0;
            if (cur.len != 0) chk("mem_req_len", 32'(run_len), 32'(cur.len));
        end
    end

    vec_t vecs[14] = '{
        '{0, 0, 3'd0, 32'h100, 32'h0,        32'hDEADBEEF, 2, 0, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 4, 3},
        '{1, 0, 3'd0, 32'h203, 32'h0,        32'h80123456, 0, 0, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 2, 1},
        '{1, 0, 3'd3, 32'h203, 32'h0,        32'h80123456, 0, 0, 1, 4'b1000, 32'h0,        32'h00000080, 0, 2, 1},
        '{1, 0, 3'd1, 32'h202, 32'h0,        32'h80017777, 0, 0, 1, 4'b1100, 32'h0,        32'hFFFF8001, 0, 2, 1},
        '{1, 0, 3'd4, 32'h200, 32'h0,        32'h1234F00D, 1, 0, 1, 4'b0011, 32'h0,        32'h0000F00D, 0, 3, 2},
        '{1, 0, 3'd2, 32'h104, 32'h0,        32'hCAFEF00D, 0, 0, 1, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 2, 1},
        '{1, 1, 3'd0, 32'h101, 32'h123456A5, 32'h55555555, 0, 0, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 2, 1},
        '{1, 1, 3'd1, 32'h102, 32'hFFFFBEEF, 32'h55555555, 0, 0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 2, 1},
        '{1, 1, 3'd2, 32'h108, 32'h01020304, 32'h55555555, 1, 0, 1, 4'b1111, 32'h01020304, 32'h0,        0, 3, 2},
        '{1, 0, 3'd2, 32'h102, 32'h0,        32'h11111111, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 1, 0},
        '{1, 0, 3'd6, 32'h100, 32'h0,        32'h11111111, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 1, 0},
        '{0, 0, 3'd0, 32'h102, 32'h0,        32'h11111111, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 1, 0},
        '{1, 0, 3'd1, 32'h203, 32'h0,        32'h11111111, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 1, 0},
        '{1, 0, 3'd2, 32'h010, 32'h0,        32'hFFFFFFFF, 0, 1, 1, 4'b1111, 32'h0,        32'h0,        1, 5, 4}
    };

    task automatic drive_idle();
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_type  = 3'd0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp_q.size() == 0) break;
        end
        chk(name, 32'(resp_q.size()), 32'h0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit got;
        mem_data  = v.memdata;
        mem_waits = v.waits;
        mem_noack = v.noack;
        gnt_q.push_back(v.is_d);
        resp_q.push_back('{is_d: v.is_d, rdata: v.rdata, err: v.err, lat: v.lat});
        if (v.has_mem)
            mem_q.push_back('{we: v.we, addr: v.addr & 32'hFFFF_FFFC, be: v.be, wdata: v.mwdata, len: v.len});
        @(posedge clk); #1;
        if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
            bus.d_wdata = v.wdata; bus.d_type = v.typ;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.if_gnt === 1'b1 || bus.d_gnt === 1'b1) begin got = 1'b1; break; end
        end
        if (!got) chk($sformatf("v%0d_gnt_timeout", idx), 32'(got), 32'h1);
        @(posedge clk); #1;
        drive_idle();
        wait_drain($sformatf("v%0d_resp_timeout", idx));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ng;
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset during an outstanding fetch drops the request without a response.
        mem_noack = 1'b1;
        gnt_q.push_back(1'b0);
        mem_q.push_back('{we: 1'b0, addr: 32'h440, be: 4'hF, wdata: 32'h0, len: 0});
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h440;
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #3;
        chk("busy_mem_req", 32'(bus.mem_req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("arst_mem_addr", bus.mem_addr, 32'h0);
        chk("arst_mem_be", 32'(bus.mem_be), 32'h0);
        chk("arst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_noack = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_req", 32'(bus.mem_req), 32'h0);

        // Both requesters held: grants alternate starting with data after reset.
        mem_data  = 32'h12345678;
        mem_waits = 0;
        for (int k = 0; k < 4; k++) begin
            bit d;
            d = (k % 2 == 0);
            gnt_q.push_back(d);
            resp_q.push_back('{is_d: d, rdata: 32'h12345678, err: 1'b0, lat: 2});
            mem_q.push_back('{we: 1'b0, addr: d ? 32'h300 : 32'h400, be: 4'hF, wdata: 32'h0, len: 1});
        end
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_type = 3'd2;
        ng = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            @(negedge clk);
            if (bus.if_gnt === 1'b1 || bus.d_gnt === 1'b1) ng++;
        end
        chk("arb_gnt_count", 32'(ng), 32'd4);
        @(posedge clk); #1;
        drive_idle();
        wait_drain("arb_resp_timeout");

        repeat (3) @(negedge clk);
        chk("gnt_q_empty", 32'(gnt_q.size()), 32'h0);
        chk("mem_q_empty", 32'(mem_q.size()), 32'h0);
        chk("resp_q_empty", 32'(resp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
